// File: rtl/bitwise_logic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_logic_pipe
//  Purpose  : One-stage registered bitwise logic unit with valid/ready
//             handshake on both sides. It computes one of eight bitwise ops
//             on IN and a second operand B. B is SV, or the last accepted
//             result when src_sel=1. It also reports how many bit positions
//             of IN and B are equal, and whether IN equals B.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_valid/in_ready   - upstream handshake
//             IN, SV              - operands (WIDTH bits)
//             op                  - 000 AND, 001 OR, 010 XOR, 011 XNOR,
//                                   100 NAND, 101 NOR, 110 NOT IN, 111 PASS IN
//             src_sel             - 0: B=SV, 1: B=previous accepted result
//             en                  - 0 forces the result to zero
//             out_valid/out_ready - downstream handshake
//             Out                 - registered result
//             match_cnt           - registered popcount of ~(IN ^ B)
//             all_eq              - registered IN == B
//  Revision : 1.0 - initial release
// ============================================================================
module bitwise_logic_pipe #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] IN,
    input  logic [WIDTH-1:0] SV,
    input  logic [2:0]       op,
    input  logic             src_sel,
    input  logic             en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic [CW-1:0]    match_cnt,
    output logic             all_eq
);

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_XOR  = 3'b010;
    localparam logic [2:0] c_OP_XNOR = 3'b011;
    localparam logic [2:0] c_OP_NAND = 3'b100;
    localparam logic [2:0] c_OP_NOR  = 3'b101;
    localparam logic [2:0] c_OP_NOT  = 3'b110;
    localparam logic [2:0] c_OP_PASS = 3'b111;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_match_cnt;
    logic             r_all_eq;
    logic             r_out_valid;

    logic             w_accept;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_match;
    logic [CW-1:0]    w_cnt;

    // The stage can take a new beat if it is empty or its beat leaves this cycle.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // r_acc changes only on accept, so a chained beat always sees the result
    // of the immediately preceding accepted beat, never a stalled one.
    assign w_b = src_sel ? r_acc : SV;

    always_comb begin
        w_f = IN;
        case (op)
            c_OP_AND:  w_f = IN & w_b;
            c_OP_OR:   w_f = IN | w_b;
            c_OP_XOR:  w_f = IN ^ w_b;
            c_OP_XNOR: w_f = ~(IN ^ w_b);
            c_OP_NAND: w_f = ~(IN & w_b);
            c_OP_NOR:  w_f = ~(IN | w_b);
            c_OP_NOT:  w_f = ~IN;
            c_OP_PASS: w_f = IN;
            default:   w_f = IN;
        endcase
    end

    assign w_res = en ? w_f : '0;

    // The equality metrics always use B, even for ops that ignore it and
    // even when en=0.
    assign w_match = ~(IN ^ w_b);

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt = w_cnt + CW'(w_match[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_match_cnt <= '0;
            r_all_eq    <= 1'b0;
            r_acc       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_res;
            r_match_cnt <= w_cnt;
            r_all_eq    <= &w_match;
            r_acc       <= w_res;
        end else if (out_ready) begin
            // Beat transferred with nothing new behind it; the data is held.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign Out       = r_out;
    assign match_cnt = r_match_cnt;
    assign all_eq    = r_all_eq;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitwise_logic_pipe
//  Purpose  : Self-checking bench for bitwise_logic_pipe (WIDTH=8 and
//             WIDTH=13 instances). It uses directed vectors with literal
//             expectations, plus a queue-based reference model that is
//             compared on every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_logic_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready, src_sel, en;
    logic [7:0] in8, sv8;
    logic [2:0] op;
    logic       in_ready, out_valid, all_eq;
    logic [7:0] out8;
    logic [3:0] match8;

    logic        in_valid13;
    logic [12:0] in13, sv13;
    logic        in_ready13, out_valid13, all_eq13;
    logic [12:0] out13;
    logic [3:0]  match13;

    int checks = 0;
    int errors = 0;
    bit rand_stall = 1'b0;

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .IN(in8), .SV(sv8), .op(op), .src_sel(src_sel), .en(en),
        .out_valid(out_valid), .out_ready(out_ready), .Out(out8),
        .match_cnt(match8), .all_eq(all_eq)
    );

    bitwise_logic_pipe #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .in_valid(in_valid13), .in_ready(in_ready13),
        .IN(in13), .SV(sv13), .op(op), .src_sel(1'b0), .en(1'b1),
        .out_valid(out_valid13), .out_ready(1'b1), .Out(out13),
        .match_cnt(match13), .all_eq(all_eq13)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] o;
        int         m;
        bit         eq;
    } exp_t;

    exp_t       q[$];
    logic [7:0] acc_m = 8'h00;

    function automatic logic [7:0] f_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a ^ b);
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // Inputs change just after the rising edge, so at the falling edge they
    // are the values the next rising edge will sample.
    always @(negedge clk) begin
        exp_t       e;
        exp_t       n;
        logic [7:0] b;
        logic [7:0] eqbits;
        bit         take;
        if (rst) begin
            q.delete();
            acc_m = 8'h00;
        end else begin
            check("out_valid", out_valid, q.size() != 0);
            check("in_ready", in_ready, (q.size() == 0) || out_ready);
            take = in_valid && ((q.size() == 0) || out_ready);
            if (q.size() != 0) begin
                e = q[0];
                check("model_Out", out8, e.o);
                check("model_match_cnt", match8, e.m);
                check("model_all_eq", all_eq, e.eq);
                if (out_ready) void'(q.pop_front());
            end
            if (take) begin
                b      = src_sel ? acc_m : sv8;
                eqbits = ~(in8 ^ b);
                n.o    = en ? f_op(op, in8, b) : 8'h00;
                n.m    = $countones(eqbits);
                n.eq   = (in8 == b);
                q.push_back(n);
                acc_m  = n.o;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] s,
                        input logic ss, input logic e);
        bit ok;
        int n = 0;
        op = o; in8 = a; sv8 = s; src_sel = ss; en = e; in_valid = 1'b1;
        do begin
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 100);
        if (!ok) check("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        sweep_exp = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A, 8'hC5};
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; src_sel = 1'b0; en = 1'b1;
        in8 = 8'hA5; sv8 = 8'h5A; op = 3'd2;
        in_valid13 = 1'b0; in13 = '0; sv13 = '0;

        // Reset held two cycles while a beat is presented; that beat is dropped.
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_Out", out8, 0);
        check("rst_match_cnt", match8, 0);
        check("rst_all_eq", all_eq, 0);
        check("rst_in_ready", in_ready, 1);
        tick();
        check("rst_no_beat", out_valid, 0);

        // Op sweep: each result must be visible one cycle after acceptance.
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 8'hC5, 8'h3A, 1'b0, 1'b1);
            check("sweep_valid", out_valid, 1);
            check("sweep_Out", out8, sweep_exp[i]);
            check("sweep_match", match8, 0);
            check("sweep_eq", all_eq, 0);
        end

        // en=0 zeroes the result but keeps the equality metrics.
        send(3'd3, 8'h5A, 8'h5A, 1'b0, 1'b0);
        check("en0_Out", out8, 8'h00);
        check("en0_match", match8, 8);
        check("en0_eq", all_eq, 1);

        // Accumulator chain.
        send(3'd2, 8'h0F, 8'hF0, 1'b0, 1'b1);
        check("chain1_Out", out8, 8'hFF);
        send(3'd2, 8'h0F, 8'hAA, 1'b1, 1'b1);
        check("chain2_Out", out8, 8'hF0);
        send(3'd0, 8'h30, 8'hAA, 1'b1, 1'b1);
        check("chain3_Out", out8, 8'h30);
        send(3'd1, 8'h12, 8'h00, 1'b0, 1'b0);
        send(3'd1, 8'h12, 8'hFF, 1'b1, 1'b1);
        check("chain_en0_acc", out8, 8'h12);
        send(3'd6, 8'h12, 8'hFF, 1'b1, 1'b1);
        check("not_srcsel_Out", out8, 8'hED);
        check("not_srcsel_match", match8, 8);

        // Backpressure: hold out_ready low for three cycles with a beat waiting.
        tick();
        out_ready = 1'b0;
        send(3'd7, 8'h77, 8'h00, 1'b0, 1'b1);
        op = 3'd7; in8 = 8'h99; sv8 = 8'h00; src_sel = 1'b0; en = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_Out_stable", out8, 8'h77);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_second_Out", out8, 8'h99);
        tick();
        check("bp_drained", out_valid, 0);

        // Random stall run scored by the model.
        rand_stall = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
        end
        rand_stall = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("final_queue_empty", q.size(), 0);
        check("final_out_valid", out_valid, 0);

        // WIDTH=13 instance.
        op = 3'd3; in13 = 13'h1FFF; sv13 = 13'h0000; in_valid13 = 1'b1;
        tick();
        in_valid13 = 1'b0;
        check("w13_valid", out_valid13, 1);
        check("w13_Out_diff", out13, 13'h0000);
        check("w13_match_diff", match13, 0);
        check("w13_eq_diff", all_eq13, 0);
        in13 = 13'h0A5B; sv13 = 13'h0A5B; in_valid13 = 1'b1;
        tick();
        in_valid13 = 1'b0;
        check("w13_Out_same", out13, 13'h1FFF);
        check("w13_match_same", match13, 13);
        check("w13_eq_same", all_eq13, 1);
        check("w13_in_ready", in_ready13, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
